// File: rtl/exp_golomb_decoder_if.sv
// Buffer-side and symbol-side signal bundle for the Exp-Golomb decoder.
//   win, level     : bit window (win[0] oldest) and fill level from the bit buffer
//   pop            : bits the decoder consumes from the buffer this cycle
//   sym_valid/ready: valid/ready handshake for a decoded symbol
//   sym            : decoded symbol value
//   error          : sticky prefix-overflow flag
// master = decoder side, slave = buffer/consumer side.
interface exp_golomb_decoder_if #(
  parameter int WINDOW      = 8,
  parameter int POP_WIDTH   = 3,
  parameter int LEVEL_WIDTH = 4,
  parameter int VALUE_WIDTH = 16
);
  logic [WINDOW-1:0]      win;
  logic [LEVEL_WIDTH-1:0] level;
  logic [POP_WIDTH-1:0]   pop;
  logic                   sym_valid;
  logic                   sym_ready;
  logic [VALUE_WIDTH-1:0] sym;
  logic                   error;

  modport master (
    input  win, level, sym_ready,
    output pop, sym_valid, sym, error
  );

  modport slave (
    output win, level, sym_ready,
    input  pop, sym_valid, sym, error
  );
endinterface

// File: rtl/exp_golomb_decoder.sv
// Order-0 Exp-Golomb decoder sitting directly behind a variable-length bit
// buffer. Each cycle it looks at the usable part of the buffer window, drives
// a combinational pop count back to the buffer, and walks a PREFIX -> SUFFIX
// -> OUT sequence, spreading long codes across several cycles. An oversize
// prefix parks the block in ERROR until reset.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : exp_golomb_decoder_if master (win/level in, pop out,
//              sym/sym_valid out with sym_ready in, sticky error out)
module exp_golomb_decoder #(
  parameter int WINDOW      = 8,
  parameter int POP_WIDTH   = 3,
  parameter int LEVEL_WIDTH = 4,
  parameter int MAX_PREFIX  = 15,
  parameter int VALUE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  exp_golomb_decoder_if.master bus
);

  localparam int POP_MAX = (1 << POP_WIDTH) - 1;
  localparam int KW      = $clog2(MAX_PREFIX + 1) + 1;
  // k + (bits examined) can exceed MAX_PREFIX by up to POP_MAX before the
  // overflow is detected, so sums are formed at this wider width.
  localparam int SW      = KW + POP_WIDTH;
  localparam int IW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    S_PREFIX,
    S_SUFFIX,
    S_OUT,
    S_ERROR
  } state_t;

  state_t                 state, state_n;
  logic [KW-1:0]          k, k_n;
  logic [KW-1:0]          rem, rem_n;
  logic [VALUE_WIDTH-1:0] acc, acc_n;
  logic [VALUE_WIDTH-1:0] sym_r, sym_n;

  logic [WINDOW-1:0]      win;
  logic [LEVEL_WIDTH-1:0] level;
  logic [POP_WIDTH-1:0]   u;
  logic                   found;
  logic [POP_WIDTH-1:0]   z;
  logic [POP_WIDTH-1:0]   n;
  logic [POP_MAX-1:0]     chunk;
  logic [IW-1:0]          idx;
  logic [VALUE_WIDTH-1:0] acc_shift;
  logic [VALUE_WIDTH-1:0] sym_val;
  logic [SW-1:0]          kz;
  logic [SW-1:0]          ku;
  logic [POP_WIDTH-1:0]   pop_c;

  assign win   = bus.win;
  assign level = bus.level;

  // Window analysis: usable bit count, first-one scan, suffix chunk.
  always_comb begin
    u         = '0;
    found     = 1'b0;
    z         = '0;
    n         = '0;
    chunk     = '0;
    idx       = '0;

    if (int'(level) > POP_MAX) u = POP_WIDTH'(POP_MAX);
    else                       u = POP_WIDTH'(level);

    // Scan downward so the lowest-index (oldest) one wins.
    for (int i = POP_MAX - 1; i >= 0; i--) begin
      if (i < int'(u) && win[i]) begin
        found = 1'b1;
        z     = POP_WIDTH'(i);
      end
    end

    if (SW'(u) < SW'(rem)) n = u;
    else                   n = POP_WIDTH'(rem);

    // Bit-reverse win[n-1:0] so the oldest suffix bit becomes the chunk MSB.
    for (int j = 0; j < POP_MAX; j++) begin
      if (j < int'(n)) begin
        idx      = IW'(int'(n) - 1 - j);
        chunk[j] = win[idx];
      end
    end

    acc_shift = (acc << n) | VALUE_WIDTH'(chunk);
    sym_val   = (VALUE_WIDTH'(1) << k) - VALUE_WIDTH'(1) + acc_shift;
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    rem_n   = rem;
    acc_n   = acc;
    sym_n   = sym_r;
    pop_c   = '0;
    kz      = SW'(k) + SW'(z);
    ku      = SW'(k) + SW'(u);

    unique case (state)
      S_PREFIX: begin
        if (found) begin
          pop_c = z + POP_WIDTH'(1);
          k_n   = KW'(kz);
          if (kz > SW'(MAX_PREFIX)) begin
            state_n = S_ERROR;
          end else if (kz == '0) begin
            sym_n   = '0;
            state_n = S_OUT;
          end else begin
            rem_n   = KW'(kz);
            state_n = S_SUFFIX;
          end
        end else begin
          // All examined bits are prefix zeros (u == 0 simply holds).
          pop_c = u;
          k_n   = KW'(ku);
          if (ku > SW'(MAX_PREFIX)) state_n = S_ERROR;
        end
      end

      S_SUFFIX: begin
        pop_c = n;
        acc_n = acc_shift;
        rem_n = rem - KW'(n);
        if (rem == KW'(n)) begin
          sym_n   = sym_val;
          state_n = S_OUT;
        end
      end

      S_OUT: begin
        if (bus.sym_ready) begin
          k_n     = '0;
          rem_n   = '0;
          acc_n   = '0;
          state_n = S_PREFIX;
        end
      end

      S_ERROR: begin
      end

      default: state_n = S_PREFIX;
    endcase

    // The buffer shares this reset, so nothing may be consumed during it.
    if (rst) pop_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_PREFIX;
      k     <= '0;
      rem   <= '0;
      acc   <= '0;
      sym_r <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      rem   <= rem_n;
      acc   <= acc_n;
      sym_r <= sym_n;
    end
  end

  assign bus.pop       = pop_c;
  assign bus.sym_valid = (state == S_OUT);
  assign bus.error     = (state == S_ERROR);
  assign bus.sym       = sym_r;

endmodule
